// File: rtl/byte_serializer_if.sv
// rtl/byte_serializer_if.sv - byte input / unit output bundle for byte_serializer
// master drives bytes and ticks; slave is the serializer.
interface byte_serializer_if;
  logic [7:0] inData;
  logic       inValid;
  logic       outReady;
  logic       inMode;
  logic       inTick;
  logic       outValid;
  logic [3:0] outSymbol;
  logic [2:0] outSel;
  logic       outLast;

  modport master (
    output inData, inValid, inMode, inTick,
    input  outReady, outValid, outSymbol, outSel, outLast
  );

  modport slave (
    input  inData, inValid, inMode, inTick,
    output outReady, outValid, outSymbol, outSel, outLast
  );
endinterface

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - splits bytes into bit or nibble units, LSB first
// One holding byte plus one active byte let the next byte follow without a gap.
module byte_serializer (
  input logic              inClk,
  input logic              inRst,
  byte_serializer_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state;
  logic [7:0] holdData;
  logic       holdMode;
  logic       holdFull;
  logic [7:0] actData;
  logic       actMode;
  logic [2:0] unitCnt;
  logic       validQ;
  logic [3:0] symQ;
  logic       lastQ;
  logic [2:0] nextCnt;

  function automatic logic [3:0] unitOf(input logic [7:0] d, input logic m, input logic [2:0] idx);
    if (m) return idx[0] ? d[7:4] : d[3:0];
    return {3'b000, d[idx]};
  endfunction

  function automatic logic isLast(input logic m, input logic [2:0] idx);
    return m ? (idx == 3'd1) : (idx == 3'd7);
  endfunction

  assign nextCnt = unitCnt + 3'd1;

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state    <= IDLE;
      holdData <= 8'd0;
      holdMode <= 1'b0;
      holdFull <= 1'b0;
      actData  <= 8'd0;
      actMode  <= 1'b0;
      unitCnt  <= 3'd0;
      validQ   <= 1'b0;
      symQ     <= 4'd0;
      lastQ    <= 1'b0;
    end else begin
      // Acceptance only while hold is empty, so it never collides with a transfer out of hold.
      if (bus.inValid && !holdFull) begin
        holdData <= bus.inData;
        holdMode <= bus.inMode;
        holdFull <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (holdFull) begin
            actData  <= holdData;
            actMode  <= holdMode;
            unitCnt  <= 3'd0;
            holdFull <= 1'b0;
            state    <= SHIFT;
            validQ   <= 1'b1;
            symQ     <= unitOf(holdData, holdMode, 3'd0);
            lastQ    <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.inTick) begin
            if (!lastQ) begin
              unitCnt <= nextCnt;
              symQ    <= unitOf(actData, actMode, nextCnt);
              lastQ   <= isLast(actMode, nextCnt);
            end else if (holdFull) begin
              actData  <= holdData;
              actMode  <= holdMode;
              unitCnt  <= 3'd0;
              holdFull <= 1'b0;
              symQ     <= unitOf(holdData, holdMode, 3'd0);
              lastQ    <= 1'b0;
            end else begin
              state   <= IDLE;
              validQ  <= 1'b0;
              unitCnt <= 3'd0;
              symQ    <= 4'd0;
              lastQ   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.outReady  = !holdFull && !inRst;
  assign bus.outValid  = validQ;
  assign bus.outSymbol = symQ;
  assign bus.outSel    = unitCnt;
  assign bus.outLast   = lastQ;
endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - scoreboard bench for byte_serializer
// Expected units are derived from each accepted byte with plain shifts and masks.
module tb_byte_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_serializer_if bus();
  byte_serializer dut (.inClk(clk), .inRst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] sym;
    logic [2:0] sel;
    logic       last;
  } unit_t;

  unit_t      expQ[$];
  logic [7:0] pendData[$];
  logic       pendMode[$];
  unit_t      mon;
  int total = 0;
  int bad = 0;
  int popped = 0;
  int validCycles = 0;
  int validRises = 0;
  int tickAge = 0;
  int expUnits = 0;
  logic prevValid = 1'b0;
  logic idleMode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushUnits(input logic [7:0] b, input logic m);
    int n;
    unit_t u;
    n = m ? 2 : 8;
    for (int i = 0; i < n; i++) begin
      u.sym  = m ? 4'((b >> (4 * i)) & 8'h0F) : 4'((b >> i) & 8'h01);
      u.sel  = 3'(i);
      u.last = (i == n - 1);
      expQ.push_back(u);
    end
  endtask

  task automatic sendLater(input logic [7:0] b, input logic m);
    pendData.push_back(b);
    pendMode.push_back(m);
  endtask

  // period 0 = random tick; otherwise tick once the shown unit has been visible period cycles
  task automatic cycle(input int period);
    logic acc;
    logic [7:0] b;
    logic m;
    bus.inValid = (pendData.size() > 0);
    bus.inData  = bus.inValid ? pendData[0] : 8'($urandom);
    bus.inMode  = bus.inValid ? pendMode[0] : idleMode;
    bus.inTick  = (period == 0) ? 1'($urandom_range(0, 1))
                                : (tickAge > 0 && (tickAge % period) == 0);
    acc = bus.inValid && bus.outReady;
    @(posedge clk);
    if (acc) begin
      b = pendData.pop_front();
      m = pendMode.pop_front();
      pushUnits(b, m);
    end
    #1;
    if (bus.outValid) begin
      validCycles++;
      tickAge++;
      if (!prevValid) validRises++;
    end else begin
      tickAge = 0;
    end
    prevValid = bus.outValid;
  endtask

  task automatic drain(input int period);
    int n;
    n = 0;
    do begin
      cycle(period);
      n++;
    end while ((pendData.size() > 0 || expQ.size() > 0 || bus.outValid) && n < 600);
    if (n >= 600) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d cycles expected idle", n);
    end
  endtask

  task automatic clr();
    popped = 0;
    validCycles = 0;
    validRises = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.outValid) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_unit: got sel=%0d sym=%0h expected none", bus.outSel, bus.outSymbol);
        end else begin
          mon = expQ[0];
          check("unit_sym", bus.outSymbol, mon.sym);
          check("unit_sel", bus.outSel, mon.sel);
          check("unit_last", bus.outLast, mon.last);
          if (bus.inTick) begin
            void'(expQ.pop_front());
            popped++;
          end
        end
      end else begin
        check("idle_sym", bus.outSymbol, 0);
        check("idle_sel", bus.outSel, 0);
        check("idle_last", bus.outLast, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic       rm;
    int         n;
    bus.inValid = 1'b0;
    bus.inData  = 8'd0;
    bus.inMode  = 1'b0;
    bus.inTick  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outReady", bus.outReady, 0);
    check("rst_outValid", bus.outValid, 0);
    check("rst_outSymbol", bus.outSymbol, 0);
    check("rst_outSel", bus.outSel, 0);
    check("rst_outLast", bus.outLast, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_outReady", bus.outReady, 1);

    // A5 bit mode, including accept-to-valid latency of two edges
    clr();
    sendLater(8'hA5, 1'b0);
    cycle(1);
    check("lat_edge1_valid", bus.outValid, 0);
    cycle(1);
    check("lat_edge2_valid", bus.outValid, 1);
    drain(1);
    check("a5_units", popped, 8);
    check("a5_validCycles", validCycles, 8);

    // 3C nibble mode
    clr();
    sendLater(8'h3C, 1'b1);
    drain(1);
    check("3c_units", popped, 2);
    check("3c_validCycles", validCycles, 2);

    // back-to-back 01, 80
    clr();
    sendLater(8'h01, 1'b0);
    sendLater(8'h80, 1'b0);
    cycle(1);
    check("b2b_ready_holdfull", bus.outReady, 0);
    drain(1);
    check("b2b_units", popped, 16);
    check("b2b_validCycles", validCycles, 16);
    check("b2b_validRises", validRises, 1);

    // FF with a tick every 4 cycles
    clr();
    sendLater(8'hFF, 1'b0);
    drain(4);
    check("slow_units", popped, 8);
    check("slow_validCycles", validCycles, 32);
    check("slow_validRises", validRises, 1);

    // reset after 3 units of F0 while 0F waits in hold
    clr();
    sendLater(8'hF0, 1'b0);
    sendLater(8'h0F, 1'b0);
    n = 0;
    while (popped < 3 && n < 40) begin
      cycle(1);
      n++;
    end
    check("mid_units_before_rst", popped, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_outValid", bus.outValid, 0);
    check("mid_rst_outSymbol", bus.outSymbol, 0);
    check("mid_rst_outSel", bus.outSel, 0);
    check("mid_rst_outLast", bus.outLast, 0);
    check("mid_rst_outReady", bus.outReady, 0);
    expQ.delete();
    pendData.delete();
    pendMode.delete();
    @(negedge clk);
    rst = 1'b0;
    clr();
    prevValid = 1'b0;
    tickAge = 0;
    repeat (20) cycle(1);
    check("post_rst_validCycles", validCycles, 0);
    check("post_rst_outReady", bus.outReady, 1);

    // mode flips while a bit-mode byte shifts
    clr();
    idleMode = 1'b1;
    sendLater(8'hA5, 1'b0);
    repeat (4) cycle(1);
    sendLater(8'h5A, 1'b1);
    drain(1);
    check("mode_units", popped, 10);
    idleMode = 1'b0;

    // randomized traffic with random ticks and gaps
    clr();
    expUnits = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0 && pendData.size() < 2) begin
        rb = 8'($urandom);
        rm = 1'($urandom);
        sendLater(rb, rm);
        expUnits += rm ? 2 : 8;
      end
      cycle(0);
    end
    drain(0);
    check("rand_units", popped, expUnits);
    check("rand_queue_empty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
